bcd_count_sequencer: RTL and testbench
======================================

// Module: bcd_count_sequencer
// PURPOSE
//  Run/pause/stop controller for the 3-digit BCD counter datapath (units/tens/hundreds).
//  Divides clk into count ticks and drives the counter's count-enable and synchronous clear.
//  Watches the counter value fed back to it and stops when that value equals a BCD target.
//  Sits between the user inputs (ui_in) and the counter, at the top level of the tile.
// PARAMETERS
//  PRESCALE_DIV  1000  clk cycles per count tick; legal range 2..65535 (elaboration error otherwise)
//  PRESCALE_W    16    prescaler register width; must satisfy 2**PRESCALE_W > PRESCALE_DIV
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, asynchronous, active-low
//  ena         in   1   tile enable; 0 freezes all state
//  start       in   1   level; IDLE/PAUSE/DONE -> RUN
//  pause       in   1   level; RUN -> PAUSE
//  clear       in   1   level; any state -> IDLE, plus a counter clear
//  target_bcd  in   12  stop value {hundreds,tens,units}, one BCD digit per nibble
//  cnt_bcd     in   12  counter value fed back, same packing as target_bcd
//  cnt_en      out  1   registered one-cycle pulse: counter increments once
//  cnt_clr     out  1   registered one-cycle pulse: counter goes to 000
//  done        out  1   registered level, 1 while in DONE
//  err         out  1   registered one-cycle pulse: start rejected
//  state       out  2   encoded FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, cnt_en=0, cnt_clr=0, done=0, err=0.
//  ena=0: FSM and prescaler hold their values; cnt_en, cnt_clr and err are forced 0 on the next edge.
//  Input priority in every cycle: clear > pause > start.
//  clear (any state): next state IDLE, prescaler<=0, cnt_clr=1 for exactly 1 cycle.
//   - clear held high: cnt_clr pulses only on the first cycle of the high level (rising-edge detect).
//  IDLE:
//   - start with a legal target -> RUN; prescaler<=0.
//   - start with any target nibble >9 -> stay IDLE; err=1 for 1 cycle.
//  RUN:
//   - prescaler counts 0..PRESCALE_DIV-1 and wraps to 0.
//   - In the cycle the prescaler equals DIV-1: the next edge sets cnt_en=1, so cnt_en is 1 for 1 cycle.
//   - Match check every cycle: cnt_bcd==target_bcd -> next state DONE, and cnt_en is suppressed.
//   - The feedback has 1-cycle latency; DIV>=2 guarantees the match is seen before the next tick,
//     so the counter never overshoots the target.
//   - pause -> PAUSE; the prescaler value is kept.
//  PAUSE:
//   - No ticks are issued and the prescaler holds.
//   - start (pause low) -> RUN; counting resumes from the held prescaler value.
//  DONE:
//   - done=1, no cnt_en.
//   - start -> RUN, with cnt_clr=1 for 1 cycle and prescaler<=0 (restart from 000).
//   - target=000 with counter 000: RUN -> DONE on the first cycle of RUN; no cnt_en ever issued.
//  Wrap: target 999 is reached without wrap. The counter wrapping 999->000 is never produced
//   by this block except via cnt_clr.
//  start and pause both high in RUN: pause wins. Both high in PAUSE: stay in PAUSE.
//  Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronously).
//   The counter has its own reset and is not cleared through cnt_clr.
//  Comparison is nibble-wise equality only. cnt_bcd digits >9 never match, so the block stays in RUN.
// STRUCTURE
//  Shared package bcd_pkg:
//   - state encoding localparams ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE
//   - BCD_DIGITS=3, BCD_W=12
//   - function bcd_legal(12-bit), shared with the counter top.
//  One sub-module: bcd_prescaler, with ports clk, rst_n, run, load0, tick (tick is combinational
//   at terminal count). The FSM, compare and output registers live here.
// TESTING (PRESCALE_DIV=4 in the bench)
//  1. Reset, target=0x005, start pulse:
//     -> cnt_en every 4th cycle, exactly 5 pulses, DONE (state=3, done=1) once the model shows 005.
//  2. Target=0x000, start:
//     -> state RUN for 1 cycle, then DONE; zero cnt_en pulses.
//  3. Target=0x020. Pause after 7 ticks, hold 10 cycles, then start:
//     -> no cnt_en during PAUSE, prescaler resumes from its held value, total 20 ticks, then done.
//  4. Target=0x0A3, start:
//     -> err=1 for 1 cycle, state stays 0, no cnt_en.
//  5. Clear held 5 cycles mid-RUN, with start also high:
//     -> one cnt_clr pulse, state=IDLE; start is ignored while clear is high.
//  6. In DONE, start:
//     -> cnt_clr pulse, RUN, recount to target. Drop ena mid-RUN for 6 cycles
//        -> tick spacing is stretched by exactly 6 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the 3-digit BCD counter tile: FSM state codes,
// BCD widths and the digit-legality helper used by the sequencer and counter top.
package bcd_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_DONE  = ST_DONE
  } state_t;

  function automatic logic bcd_legal(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_prescaler.sv
// Count-tick prescaler: counts 0..PRESCALE_DIV-1 while run is high and
// flags the terminal count combinationally on tick.
module bcd_prescaler #(
  parameter int PRESCALE_DIV = 1000,
  parameter int PRESCALE_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic load0,
  output logic tick
);

  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 65535 ||
      (64'(1) << PRESCALE_W) <= 64'(PRESCALE_DIV)) begin : g_bad_div
    $error("bcd_prescaler: PRESCALE_DIV out of range or PRESCALE_W too narrow");
  end

  localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(PRESCALE_DIV - 1);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = run && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load0) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/bcd_count_sequencer.sv
// Run/pause/stop controller for the 3-digit BCD counter: issues count-enable
// ticks, counter clears, and stops when the fed-back count equals the target.
module bcd_count_sequencer
  import bcd_pkg::*;
#(
  parameter int PRESCALE_DIV = 1000,
  parameter int PRESCALE_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic [11:0] target_bcd,
  input  logic [11:0] cnt_bcd,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        done,
  output logic        err,
  output logic [1:0]  state
);

  state_t st;
  logic   clear_q;
  logic   tick;
  logic   run;
  logic   load0;
  logic   match;
  logic   start_ok;
  logic   restart;

  // While cnt_clr is high the counter has not yet been cleared, so its stale
  // value must not be mistaken for a hit on the target.
  assign match    = (cnt_bcd == target_bcd) && bcd_legal(cnt_bcd) && !cnt_clr;
  assign start_ok = bcd_legal(target_bcd);
  assign restart  = start && !pause && start_ok && (st == S_IDLE || st == S_DONE);

  assign run   = ena && (st == S_RUN) && !clear && !pause && !match;
  assign load0 = ena && (clear || restart);

  assign state = st;

  bcd_prescaler #(
    .PRESCALE_DIV (PRESCALE_DIV),
    .PRESCALE_W   (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .load0 (load0),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      clear_q <= 1'b0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else if (!ena) begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      err     <= 1'b0;
    end else begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      err     <= 1'b0;
      clear_q <= clear;
      if (clear) begin
        st      <= S_IDLE;
        done    <= 1'b0;
        cnt_clr <= !clear_q;
      end else if (pause) begin
        if (st == S_RUN) st <= S_PAUSE;
      end else begin
        case (st)
          S_IDLE: begin
            if (start) begin
              if (start_ok) st <= S_RUN;
              else          err <= 1'b1;
            end
          end
          S_RUN: begin
            if (match) begin
              st   <= S_DONE;
              done <= 1'b1;
            end else begin
              cnt_en <= tick;
            end
          end
          S_PAUSE: begin
            if (start) st <= S_RUN;
          end
          S_DONE: begin
            if (start) begin
              if (start_ok) begin
                st      <= S_RUN;
                done    <= 1'b0;
                cnt_clr <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Self-checking bench for bcd_count_sequencer with a behavioural BCD counter
// closing the feedback loop; expectations come from decimal target arithmetic.
module tb_bcd_count_sequencer;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, pause, clear;
  logic [11:0] target_bcd, cnt_bcd;
  logic        cnt_en, cnt_clr, done, err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_en   = 0;
  int n_clr  = 0;
  int n_err  = 0;
  int val    = 0;
  int tick_t[$];

  bcd_count_sequencer #(.PRESCALE_DIV(DIV), .PRESCALE_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .target_bcd (target_bcd),
    .cnt_bcd    (cnt_bcd),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .done       (done),
    .err        (err),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Behavioural 3-digit counter with its own reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       val <= 0;
    else if (cnt_clr) val <= 0;
    else if (cnt_en)  val <= (val + 1) % 1000;
  end
  assign cnt_bcd = to_bcd(val);

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cnt_en === 1'b1) begin
      n_en++;
      tick_t.push_back(cyc);
    end
    if (cnt_clr === 1'b1) n_clr++;
    if (err === 1'b1) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_ticks(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (n_en >= n) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [11:0] tgt);
    int  t, e0, sc, bad;
    bit  ok;
    t = from_bcd(tgt);
    do_clear();
    target_bcd = tgt;
    tick_t.delete();
    e0 = n_en;
    sc = cyc;
    pulse_start();
    wait_done((t + 3) * DIV + 20, ok);
    chk({tag, "_done_reached"}, 32'(ok), 32'd1);
    chk({tag, "_ticks"}, 32'(n_en - e0), 32'(t));
    chk({tag, "_count"}, 32'(val), 32'(t));
    chk({tag, "_state"}, 32'(state), 32'd3);
    if (t > 0) begin
      chk({tag, "_first_tick"}, 32'(tick_t[0]), 32'(sc + DIV + 1));
      bad = 0;
      for (int i = 1; i < tick_t.size(); i++)
        if (tick_t[i] - tick_t[i-1] != DIV) bad++;
      chk({tag, "_spacing"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    int  e0, e1, c0, r0, t, k, bad, stretched;
    bit  ok;
    logic [11:0] tgt;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
    target_bcd = 12'h000;
    step(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt_en", 32'(cnt_en), 32'd0);
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step(2);

    run_and_check("t005", 12'h005);
    chk("t005_done_level", 32'(done), 32'd1);

    // Zero target: one RUN cycle then DONE, no ticks
    do_clear();
    target_bcd = 12'h000;
    e0 = n_en;
    pulse_start();
    chk("t000_run_cycle", 32'(state), 32'd1);
    step(1);
    chk("t000_state", 32'(state), 32'd3);
    chk("t000_done", 32'(done), 32'd1);
    step(3);
    chk("t000_ticks", 32'(n_en - e0), 32'd0);

    // Pause after 7 ticks for 10 cycles, then resume
    do_clear();
    target_bcd = 12'h020;
    tick_t.delete();
    e0 = n_en;
    pulse_start();
    wait_ticks(e0 + 7, 8 * DIV + 10, ok);
    chk("pause_reach7", 32'(ok), 32'd1);
    pause = 1'b1;
    step(10);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_no_ticks", 32'(n_en - e0), 32'd7);
    pause = 1'b0;
    pulse_start();
    wait_done(20 * DIV + 20, ok);
    chk("pause_done_reached", 32'(ok), 32'd1);
    chk("pause_total_ticks", 32'(n_en - e0), 32'd20);
    chk("pause_count", 32'(val), 32'd20);
    if (tick_t.size() > 7)
      chk("pause_resume_gap", 32'(tick_t[7] - tick_t[6]), 32'(DIV + 11));
    else
      chk("pause_tick_log", 32'(tick_t.size()), 32'd20);

    // Illegal target rejected
    do_clear();
    target_bcd = 12'h0A3;
    e0 = n_en;
    r0 = n_err;
    pulse_start();
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_state", 32'(state), 32'd0);
    step(1);
    chk("bad_err_pulse", 32'(err), 32'd0);
    step(4);
    chk("bad_no_ticks", 32'(n_en - e0), 32'd0);
    chk("bad_err_count", 32'(n_err - r0), 32'd1);

    // Clear held 5 cycles mid-RUN with start high
    do_clear();
    target_bcd = 12'h009;
    e0 = n_en;
    pulse_start();
    wait_ticks(e0 + 2, 3 * DIV + 10, ok);
    chk("clr_reach2", 32'(ok), 32'd1);
    e1 = n_en;
    c0 = n_clr;
    clear = 1'b1;
    start = 1'b1;
    step(5);
    chk("clr_state_held", 32'(state), 32'd0);
    chk("clr_one_pulse", 32'(n_clr - c0), 32'd1);
    clear = 1'b0;
    start = 1'b0;
    step(2);
    chk("clr_state_after", 32'(state), 32'd0);
    chk("clr_no_ticks", 32'(n_en - e1), 32'd0);
    chk("clr_count", 32'(val), 32'd0);

    // Restart from DONE, with ena dropped for 6 cycles mid-run
    t = $urandom_range(3, 12);
    run_and_check("restart_first", to_bcd(t));
    tick_t.delete();
    e0 = n_en;
    pulse_start();
    chk("restart_cnt_clr", 32'(cnt_clr), 32'd1);
    chk("restart_state", 32'(state), 32'd1);
    wait_ticks(e0 + 2, 3 * DIV + 10, ok);
    chk("restart_reach2", 32'(ok), 32'd1);
    ena = 1'b0;
    step(6);
    chk("ena_hold_state", 32'(state), 32'd1);
    ena = 1'b1;
    wait_done((t + 3) * DIV + 30, ok);
    chk("restart_done_reached", 32'(ok), 32'd1);
    chk("restart_ticks", 32'(n_en - e0), 32'(t));
    chk("restart_count", 32'(val), 32'(t));
    bad = 0;
    stretched = 0;
    for (int i = 1; i < tick_t.size(); i++) begin
      if (tick_t[i] - tick_t[i-1] == DIV + 6) stretched++;
      else if (tick_t[i] - tick_t[i-1] != DIV) bad++;
    end
    chk("ena_stretch_once", 32'(stretched), 32'd1);
    chk("ena_other_gaps", 32'(bad), 32'd0);

    // Randomised legal and illegal targets
    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        tgt = to_bcd($urandom_range(0, 999));
        k = $urandom_range(0, 2);
        tgt[4*k +: 4] = 4'($urandom_range(10, 15));
        do_clear();
        target_bcd = tgt;
        e0 = n_en;
        pulse_start();
        chk("rnd_bad_err", 32'(err), 32'd1);
        step(3);
        chk("rnd_bad_state", 32'(state), 32'd0);
        chk("rnd_bad_ticks", 32'(n_en - e0), 32'd0);
      end else begin
        run_and_check("rnd", to_bcd($urandom_range(0, 20)));
      end
    end

    run_and_check("t999", 12'h999);

    // Asynchronous reset while cnt_en is high
    do_clear();
    target_bcd = 12'h050;
    pulse_start();
    step(DIV);
    chk("arst_pre_tick", 32'(cnt_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_cnt_en", 32'(cnt_en), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("arst_idle_after", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
